// File: rtl/pcpi_dispatch.sv
// rtl/pcpi_dispatch.sv - PCPI sequencer for the shared RV32M multiply and divide units
// Claims enabled M-ext requests, drives one unit at a time and returns a registered response.
module pcpi_dispatch #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  input  logic        mul_en,
  input  logic        div_en,
  output logic [31:0] unit_insn,
  output logic [31:0] unit_rs1,
  output logic [31:0] unit_rs2,
  output logic        pcpi_mul_valid,
  input  logic        pcpi_mul_wr,
  input  logic [31:0] pcpi_mul_rd,
  input  logic        pcpi_mul_wait,
  input  logic        pcpi_mul_ready,
  output logic        pcpi_div_valid,
  input  logic        pcpi_div_wr,
  input  logic [31:0] pcpi_div_rd,
  input  logic        pcpi_div_wait,
  input  logic        pcpi_div_ready,
  output logic        busy,
  output logic        timeout_evt
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_div_q, sel_div_d;
  logic [31:0]   unit_insn_q, unit_insn_d;
  logic [31:0]   unit_rs1_q, unit_rs1_d;
  logic [31:0]   unit_rs2_q, unit_rs2_d;
  logic          pcpi_wr_q, pcpi_wr_d;
  logic [31:0]   pcpi_rd_q, pcpi_rd_d;
  logic          pcpi_wait_q, pcpi_wait_d;
  logic          pcpi_ready_q, pcpi_ready_d;
  logic          mul_valid_q, mul_valid_d;
  logic          div_valid_q, div_valid_d;
  logic          busy_q, busy_d;
  logic          timeout_evt_q, timeout_evt_d;

  logic          is_mext, is_div, claim;
  logic          sel_ready, sel_wr;
  logic [31:0]   sel_rd;
  logic          unused_wait;

  // The units' own wait lines carry no information the watchdog needs.
  assign unused_wait = pcpi_mul_wait ^ pcpi_div_wait;

  assign is_mext = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
  assign is_div  = pcpi_insn[14];
  assign claim   = pcpi_valid && is_mext && (is_div ? div_en : mul_en);

  assign sel_ready = sel_div_q ? pcpi_div_ready : pcpi_mul_ready;
  assign sel_wr    = sel_div_q ? pcpi_div_wr    : pcpi_mul_wr;
  assign sel_rd    = sel_div_q ? pcpi_div_rd    : pcpi_mul_rd;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_div_d     = sel_div_q;
    unit_insn_d   = unit_insn_q;
    unit_rs1_d    = unit_rs1_q;
    unit_rs2_d    = unit_rs2_q;
    pcpi_rd_d     = pcpi_rd_q;
    pcpi_wr_d     = 1'b0;
    timeout_evt_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (claim) begin
          state_d     = ST_BUSY;
          sel_div_d   = is_div;
          unit_insn_d = pcpi_insn;
          unit_rs1_d  = pcpi_rs1;
          unit_rs2_d  = pcpi_rs2;
          cnt_d       = '0;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A core abort outranks a response; a response on the last watchdog cycle outranks timeout.
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
        end else if (sel_ready) begin
          state_d   = ST_RESP;
          pcpi_wr_d = sel_wr;
          pcpi_rd_d = sel_rd;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_DRAIN;
          timeout_evt_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pcpi_valid) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pcpi_wait_d  = (state_d == ST_BUSY);
    mul_valid_d  = (state_d == ST_BUSY) && !sel_div_d;
    div_valid_d  = (state_d == ST_BUSY) && sel_div_d;
    pcpi_ready_d = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sel_div_q     <= 1'b0;
      unit_insn_q   <= '0;
      unit_rs1_q    <= '0;
      unit_rs2_q    <= '0;
      pcpi_wr_q     <= 1'b0;
      pcpi_rd_q     <= '0;
      pcpi_wait_q   <= 1'b0;
      pcpi_ready_q  <= 1'b0;
      mul_valid_q   <= 1'b0;
      div_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_div_q     <= sel_div_d;
      unit_insn_q   <= unit_insn_d;
      unit_rs1_q    <= unit_rs1_d;
      unit_rs2_q    <= unit_rs2_d;
      pcpi_wr_q     <= pcpi_wr_d;
      pcpi_rd_q     <= pcpi_rd_d;
      pcpi_wait_q   <= pcpi_wait_d;
      pcpi_ready_q  <= pcpi_ready_d;
      mul_valid_q   <= mul_valid_d;
      div_valid_q   <= div_valid_d;
      busy_q        <= busy_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign pcpi_wr        = pcpi_wr_q;
  assign pcpi_rd        = pcpi_rd_q;
  assign pcpi_wait      = pcpi_wait_q;
  assign pcpi_ready     = pcpi_ready_q;
  assign unit_insn      = unit_insn_q;
  assign unit_rs1       = unit_rs1_q;
  assign unit_rs2       = unit_rs2_q;
  assign pcpi_mul_valid = mul_valid_q;
  assign pcpi_div_valid = div_valid_q;
  assign busy           = busy_q;
  assign timeout_evt    = timeout_evt_q;
endmodule
